// File: rtl/grid_display_reader_pkg.sv
// rtl/grid_display_reader_pkg.sv - shared VGA timing, playfield geometry and RGB332 layout
package grid_display_reader_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_TOTAL_DEF   = 800;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_TOTAL_DEF   = 525;
    localparam int ORIGIN_X_DEF  = 240;
    localparam int ORIGIN_Y_DEF  = 80;
    localparam int GRID_COLS_DEF = 10;
    localparam int GRID_ROWS_DEF = 20;

    localparam int CELL_SHIFT = 4;
    localparam int CNT_W      = 10;
    localparam int ADDR_W     = 8;
    localparam int COL_W      = 4;
    localparam int ROW_W      = 5;

    // RGB332 byte layout: red in [7:5], green in [4:2], blue in [1:0]
    typedef struct packed {
        logic [2:0] red;
        logic [2:0] green;
        logic [1:0] blue;
    } rgb332_t;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic active;
        logic frame_start;
    } video_ctl_t;

    localparam video_ctl_t CTL_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, active: 1'b0, frame_start: 1'b0};

    // row*10 + col built from shifts so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] cell_address(input logic [ROW_W-1:0] row,
                                                       input logic [COL_W-1:0] col);
        return ADDR_W'({row, 3'b000}) + ADDR_W'({row, 1'b0}) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/grid_display_reader_vga_timing.sv
// rtl/grid_display_reader_vga_timing.sv - h/v counters with raw sync, active and frame-start flags
module vga_timing
    import grid_display_reader_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_TOTAL   = H_TOTAL_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_TOTAL   = V_TOTAL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output video_ctl_t       ctl_o
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q + CNT_W'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        ctl_o             = CTL_IDLE;
        ctl_o.hsync_n     = !((h_q >= HS_START) && (h_q < HS_END));
        ctl_o.vsync_n     = !((v_q >= VS_START) && (v_q < VS_END));
        ctl_o.active      = (h_q < H_VIS) && (v_q < V_VIS);
        ctl_o.frame_start = (h_q == '0) && (v_q == '0);
    end

    assign h_o = h_q;
    assign v_o = v_q;

endmodule

// File: rtl/grid_display_reader.sv
// rtl/grid_display_reader.sv - playfield RAM reader producing aligned VGA colour and sync
module grid_display_reader
    import grid_display_reader_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_TOTAL   = H_TOTAL_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_TOTAL   = V_TOTAL_DEF,
    parameter int ORIGIN_X  = ORIGIN_X_DEF,
    parameter int ORIGIN_Y  = ORIGIN_Y_DEF,
    parameter int GRID_COLS = GRID_COLS_DEF,
    parameter int GRID_ROWS = GRID_ROWS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] grid_address,
    output logic              grid_read_en,
    input  logic [7:0]        tetris_grid_in,
    output logic              hsync,
    output logic              vsync,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [1:0]        blue,
    output logic              video_active,
    output logic              frame_start
);

    localparam logic [CNT_W-1:0] GX_LO = CNT_W'(ORIGIN_X);
    localparam logic [CNT_W-1:0] GX_HI = CNT_W'(ORIGIN_X + (GRID_COLS << CELL_SHIFT));
    localparam logic [CNT_W-1:0] GY_LO = CNT_W'(ORIGIN_Y);
    localparam logic [CNT_W-1:0] GY_HI = CNT_W'(ORIGIN_Y + (GRID_ROWS << CELL_SHIFT));

    logic [CNT_W-1:0] h, v;
    video_ctl_t       ctl0;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_TOTAL   (H_TOTAL),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_TOTAL   (V_TOTAL)
    ) u_timing (
        .clk   (clk),
        .reset (reset),
        .h_o   (h),
        .v_o   (v),
        .ctl_o (ctl0)
    );

    logic             in_grid;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    always_comb begin
        in_grid = (h >= GX_LO) && (h < GX_HI) && (v >= GY_LO) && (v < GY_HI);
        col     = COL_W'((h - GX_LO) >> CELL_SHIFT);
        row     = ROW_W'((v - GY_LO) >> CELL_SHIFT);
    end

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              en1_q, en2_q;
    video_ctl_t        ctl1_q, ctl2_q, ctl3_q;
    rgb332_t           rgb_q, rgb_d;

    // RAM data is only trusted in the cycle matched to a registered read
    always_comb begin
        addr_d = addr_q;
        if (in_grid) begin
            addr_d = cell_address(row, col);
        end
        rgb_d = '0;
        if (en2_q && ctl2_q.active) begin
            rgb_d = rgb332_t'(tetris_grid_in);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            en1_q  <= 1'b0;
            en2_q  <= 1'b0;
            ctl1_q <= CTL_IDLE;
            ctl2_q <= CTL_IDLE;
            ctl3_q <= CTL_IDLE;
            rgb_q  <= '0;
        end else begin
            addr_q <= addr_d;
            en1_q  <= in_grid;
            en2_q  <= en1_q;
            ctl1_q <= ctl0;
            ctl2_q <= ctl1_q;
            ctl3_q <= ctl2_q;
            rgb_q  <= rgb_d;
        end
    end

    assign grid_address = addr_q;
    assign grid_read_en = en1_q;
    assign hsync        = ctl3_q.hsync_n;
    assign vsync        = ctl3_q.vsync_n;
    assign video_active = ctl3_q.active;
    assign frame_start  = ctl3_q.frame_start;
    assign red          = rgb_q.red;
    assign green        = rgb_q.green;
    assign blue         = rgb_q.blue;

endmodule

// File: tb/tb_grid_display_reader.sv
// tb/tb_grid_display_reader.sv - randomized playfield contents checked against a pixel-level reference
module tb_grid_display_reader;

    localparam int HV = 168;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HT = 176;
    localparam int VV = 324;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VT = 328;
    localparam int OX = 4;
    localparam int OY = 2;
    localparam int GC = 10;
    localparam int GR = 20;
    localparam int FRAME = HT * VT;
    localparam int REC_N = 6000;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       fs;
        logic [7:0] rgb;
    } pix_t;

    localparam pix_t PIX_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0, rgb: 8'h00};

    logic       clk;
    logic       reset;
    logic [7:0] grid_address;
    logic       grid_read_en;
    logic [7:0] tetris_grid_in;
    logic       hsync, vsync;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       video_active, frame_start;
    logic [11:0] out_vec;

    assign out_vec = {hsync, vsync, video_active, frame_start, red, green, blue};

    grid_display_reader #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_TOTAL (HT),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_TOTAL (VT),
        .ORIGIN_X  (OX), .ORIGIN_Y (OY), .GRID_COLS (GC), .GRID_ROWS (GR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .grid_address   (grid_address),
        .grid_read_en   (grid_read_en),
        .tetris_grid_in (tetris_grid_in),
        .hsync          (hsync),
        .vsync          (vsync),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .video_active   (video_active),
        .frame_start    (frame_start)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    logic [7:0]  mem [256];
    logic [11:0] rec [REC_N];
    pix_t        pipe [$];
    int          hm, vm;
    logic [7:0]  exp_addr, prev_addr;
    logic        exp_en, prev_en;
    int          n_assert, n_fail;
    int          fs_cnt, hs_low, vs_low;

    function automatic bit in_grid(input int h, input int v);
        return (h >= OX) && (h < OX + GC * 16) && (v >= OY) && (v < OY + GR * 16);
    endfunction

    function automatic int cell_of(input int h, input int v);
        return ((v - OY) / 16) * GC + (h - OX) / 16;
    endfunction

    function automatic pix_t pixel_at(input int h, input int v);
        pix_t p;
        p.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
        p.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
        p.act = (h < HV) && (v < VV);
        p.fs  = (h == 0) && (v == 0);
        p.rgb = in_grid(h, v) ? mem[cell_of(h, v)] : 8'h00;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the reference, check all outputs, then act as the synchronous RAM
    task automatic tick(input logic rst);
        pix_t exp_out;
        reset = rst;
        @(posedge clk);
        if (rst) begin
            exp_out = PIX_IDLE;
            pipe.delete();
            pipe.push_back(PIX_IDLE);
            pipe.push_back(PIX_IDLE);
            hm = 0;
            vm = 0;
            exp_en = 1'b0;
            exp_addr = 8'h00;
        end else begin
            pipe.push_back(pixel_at(hm, vm));
            exp_out = pipe.pop_front();
            exp_en = in_grid(hm, vm);
            if (exp_en) exp_addr = 8'(cell_of(hm, vm));
            hm++;
            if (hm == HT) begin
                hm = 0;
                vm++;
                if (vm == VT) vm = 0;
            end
        end
        #1;
        chk("video_out", out_vec, exp_out);
        chk("read_en", grid_read_en, exp_en);
        chk("address", grid_address, exp_addr);
        chk("addr_range", grid_address <= 8'd199, 1'b1);
        tetris_grid_in = prev_en ? mem[prev_addr] : 8'hFF;
        prev_en = grid_read_en;
        prev_addr = grid_address;
    endtask

    localparam int K_199   = (OY + 319) * HT + OX + 159 - 2;
    localparam int K_RED   = (OY + 7) * HT + OX + 5;
    localparam int K_BLANK = (OY + 7) * HT + HV + 1;
    localparam int K_OUT   = (OY + 7) * HT + OX + 162;
    localparam int K_RST   = 20 * HT + 100 - 1;

    initial begin
        n_assert = 0;
        n_fail = 0;
        reset = 1'b1;
        tetris_grid_in = 8'h00;
        prev_en = 1'b0;
        prev_addr = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE0;

        tick(1'b1);
        tick(1'b1);
        chk("reset_outputs", out_vec, 12'hC00);
        chk("reset_read_en", grid_read_en, 1'b0);
        chk("reset_address", grid_address, 8'h00);

        tick(1'b0);
        chk("fs_release_1", frame_start, 1'b0);
        tick(1'b0);
        chk("fs_release_2", frame_start, 1'b0);
        tick(1'b0);
        chk("fs_release_3", frame_start, 1'b1);

        fs_cnt = 0;
        hs_low = 0;
        vs_low = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) tick(1'b0);
            if (k < REC_N) rec[k] = out_vec;
            fs_cnt += int'(frame_start);
            hs_low += int'(!hsync);
            vs_low += int'(!vsync);
            if (k == K_199) begin
                chk("addr_row19_col9", grid_address, 8'd199);
                chk("read_en_col9", grid_read_en, 1'b1);
            end
            if (k == K_199 + 1) chk("read_en_past_col9", grid_read_en, 1'b0);
            if (k == K_RED) chk("cell0_colour", {red, green, blue}, 8'hE0);
            if (k == K_BLANK) chk("blank_colour", {red, green, blue}, 8'h00);
            if (k == K_OUT) chk("outside_colour", {red, green, blue}, 8'h00);
        end
        chk("fs_per_frame", fs_cnt, 1);
        chk("hsync_low_clocks", hs_low, HS * VT);
        chk("vsync_low_clocks", vs_low, VS * HT);
        tick(1'b0);
        chk("fs_period", frame_start, 1'b1);

        for (int k = 0; k < K_RST; k++) tick(1'b0);
        tick(1'b1);
        chk("midframe_reset_outputs", out_vec, 12'hC00);
        tick(1'b1);
        chk("midframe_reset_outputs_2", out_vec, 12'hC00);
        chk("midframe_reset_read_en", grid_read_en, 1'b0);
        tick(1'b0);
        chk("fs_rerelease_1", frame_start, 1'b0);
        tick(1'b0);
        chk("fs_rerelease_2", frame_start, 1'b0);
        tick(1'b0);
        chk("fs_rerelease_3", frame_start, 1'b1);
        chk("replay_0", out_vec, rec[0]);
        for (int k = 1; k < REC_N; k++) begin
            tick(1'b0);
            chk("replay", out_vec, rec[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
